n1_pbus_seq: RTL and testbench

N1_PBUS_SEQ -- requirements
Module: N1_pbus_seq

---
 rtl/n1_pbus_pkg.sv | 15 +
 rtl/n1_pbus_seq.sv | 124 ++++++++++++
 tb/tb_n1_pbus_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/n1_pbus_pkg.sv
// Shared definitions for the program-bus sequencer: request type codes and FSM states.
package N1_pbus_pkg;

  localparam logic [1:0] TYP_SEQ = 2'b00;
  localparam logic [1:0] TYP_COF = 2'b01;
  localparam logic [1:0] TYP_RD  = 2'b10;
  localparam logic [1:0] TYP_WR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

endpackage

// File: rtl/n1_pbus_seq.sv
// Program-bus sequencer: turns fetch/COF/data requests into single outstanding
// Wishbone-pipelined accesses and keeps the program counter.
module n1_pbus_seq
  import N1_pbus_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk_i,
  input  logic        async_rst_n_i,
  input  logic        fc2ps_req_i,
  input  logic [1:0]  fc2ps_typ_i,
  input  logic [15:0] fc2ps_wdat_i,
  output logic        ps2fc_gnt_o,
  output logic        ps2fc_err_o,
  input  logic        pagu2ps_adr_sel_i,
  input  logic [15:0] pagu2ps_aadr_i,
  input  logic [15:0] pagu2ps_radr_i,
  output logic [15:0] ps2ir_opc_o,
  output logic        ps2ir_opc_vld_o,
  output logic [15:0] ps2dat_rdat_o,
  output logic        ps2dat_rdat_vld_o,
  output logic [15:0] ps_pc_o,
  output logic        pbus_cyc_o,
  output logic        pbus_stb_o,
  output logic        pbus_we_o,
  output logic [15:0] pbus_adr_o,
  output logic [15:0] pbus_dat_o,
  output logic        pbus_tga_cof_o,
  output logic        pbus_tga_dat_o,
  input  logic        pbus_ack_i,
  input  logic        pbus_err_i,
  input  logic        pbus_stall_i,
  input  logic [15:0] pbus_dat_i
);

  state_t      state;
  logic [1:0]  typ_q;
  logic        bus_term;
  logic [15:0] cap_adr;

  // A new request is accepted in IDLE or in the terminating DATA cycle,
  // so back-to-back accesses keep cyc asserted.
  always_comb begin
    bus_term    = pbus_ack_i | pbus_err_i;
    ps2fc_gnt_o = async_rst_n_i & fc2ps_req_i &
                  ((state == IDLE) | ((state == DATA) & bus_term));
    case (fc2ps_typ_i)
      TYP_SEQ: cap_adr = ps_pc_o;
      TYP_COF: cap_adr = pagu2ps_adr_sel_i ? pagu2ps_aadr_i : pagu2ps_radr_i;
      default: cap_adr = pagu2ps_aadr_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      state             <= IDLE;
      typ_q             <= TYP_SEQ;
      ps_pc_o           <= PC_RESET;
      pbus_cyc_o        <= 1'b0;
      pbus_stb_o        <= 1'b0;
      pbus_we_o         <= 1'b0;
      pbus_tga_cof_o    <= 1'b0;
      pbus_tga_dat_o    <= 1'b0;
      pbus_adr_o        <= 16'h0000;
      pbus_dat_o        <= 16'h0000;
      ps2ir_opc_o       <= 16'h0000;
      ps2ir_opc_vld_o   <= 1'b0;
      ps2dat_rdat_o     <= 16'h0000;
      ps2dat_rdat_vld_o <= 1'b0;
      ps2fc_err_o       <= 1'b0;
    end else begin
      ps2ir_opc_vld_o   <= 1'b0;
      ps2dat_rdat_vld_o <= 1'b0;
      ps2fc_err_o       <= 1'b0;

      case (state)
        ADDR: if (!pbus_stall_i) begin
          pbus_stb_o <= 1'b0;
          state      <= DATA;
        end
        DATA: if (bus_term) begin
          // err wins over a simultaneous ack and suppresses data delivery
          if (pbus_err_i) begin
            ps2fc_err_o <= 1'b1;
          end else begin
            case (typ_q)
              TYP_SEQ, TYP_COF: begin
                ps2ir_opc_o     <= pbus_dat_i;
                ps2ir_opc_vld_o <= 1'b1;
              end
              TYP_RD: begin
                ps2dat_rdat_o     <= pbus_dat_i;
                ps2dat_rdat_vld_o <= 1'b1;
              end
              default: ;
            endcase
          end
          pbus_cyc_o <= 1'b0;
          state      <= IDLE;
        end
        default: ;
      endcase

      // A grant overrides the DATA->IDLE exit above.
      if (ps2fc_gnt_o) begin
        state          <= ADDR;
        typ_q          <= fc2ps_typ_i;
        pbus_cyc_o     <= 1'b1;
        pbus_stb_o     <= 1'b1;
        pbus_adr_o     <= cap_adr;
        pbus_dat_o     <= fc2ps_wdat_i;
        pbus_we_o      <= (fc2ps_typ_i == TYP_WR);
        pbus_tga_cof_o <= (fc2ps_typ_i == TYP_COF);
        pbus_tga_dat_o <= (fc2ps_typ_i == TYP_RD) | (fc2ps_typ_i == TYP_WR);
        case (fc2ps_typ_i)
          TYP_SEQ: ps_pc_o <= ps_pc_o + 16'h0001;
          TYP_COF: ps_pc_o <= cap_adr + 16'h0001;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n1_pbus_seq.sv
// Directed + randomized bench for n1_pbus_seq against a transaction-level model.
module tb_n1_pbus_seq;
  import N1_pbus_pkg::*;

  logic        clk_i = 1'b0;
  logic        async_rst_n_i;
  logic        fc2ps_req_i;
  logic [1:0]  fc2ps_typ_i;
  logic [15:0] fc2ps_wdat_i;
  logic        ps2fc_gnt_o, ps2fc_err_o;
  logic        pagu2ps_adr_sel_i;
  logic [15:0] pagu2ps_aadr_i, pagu2ps_radr_i;
  logic [15:0] ps2ir_opc_o, ps2dat_rdat_o, ps_pc_o;
  logic        ps2ir_opc_vld_o, ps2dat_rdat_vld_o;
  logic        pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_tga_cof_o, pbus_tga_dat_o;
  logic [15:0] pbus_adr_o, pbus_dat_o, pbus_dat_i;
  logic        pbus_ack_i, pbus_err_i, pbus_stall_i;

  n1_pbus_seq #(.PC_RESET(16'h0000)) dut (
    .clk_i(clk_i), .async_rst_n_i(async_rst_n_i),
    .fc2ps_req_i(fc2ps_req_i), .fc2ps_typ_i(fc2ps_typ_i), .fc2ps_wdat_i(fc2ps_wdat_i),
    .ps2fc_gnt_o(ps2fc_gnt_o), .ps2fc_err_o(ps2fc_err_o),
    .pagu2ps_adr_sel_i(pagu2ps_adr_sel_i), .pagu2ps_aadr_i(pagu2ps_aadr_i),
    .pagu2ps_radr_i(pagu2ps_radr_i),
    .ps2ir_opc_o(ps2ir_opc_o), .ps2ir_opc_vld_o(ps2ir_opc_vld_o),
    .ps2dat_rdat_o(ps2dat_rdat_o), .ps2dat_rdat_vld_o(ps2dat_rdat_vld_o),
    .ps_pc_o(ps_pc_o),
    .pbus_cyc_o(pbus_cyc_o), .pbus_stb_o(pbus_stb_o), .pbus_we_o(pbus_we_o),
    .pbus_adr_o(pbus_adr_o), .pbus_dat_o(pbus_dat_o),
    .pbus_tga_cof_o(pbus_tga_cof_o), .pbus_tga_dat_o(pbus_tga_dat_o),
    .pbus_ack_i(pbus_ack_i), .pbus_err_i(pbus_err_i), .pbus_stall_i(pbus_stall_i),
    .pbus_dat_i(pbus_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int n_run = 0;
  int n_fail = 0;

  // Model: program counter, last delivered opcode/read data, access in flight
  logic [15:0] m_pc, m_opc, m_rdat;
  logic [1:0]  e_typ, d_typ;
  logic [15:0] e_adr, e_wd;
  int          d_term;
  logic [15:0] d_bd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request and records what the bus access and PC should become.
  task automatic present(input logic [1:0] typ, input logic [15:0] wd, input logic sel,
                         input logic [15:0] aa, input logic [15:0] ra);
    fc2ps_req_i = 1'b1; fc2ps_typ_i = typ; fc2ps_wdat_i = wd;
    pagu2ps_adr_sel_i = sel; pagu2ps_aadr_i = aa; pagu2ps_radr_i = ra;
    e_typ = typ; e_wd = wd;
    if (typ == TYP_SEQ)      e_adr = m_pc;
    else if (typ == TYP_COF) e_adr = sel ? aa : ra;
    else                     e_adr = aa;
    if (typ == TYP_SEQ)      m_pc = m_pc + 16'd1;
    else if (typ == TYP_COF) m_pc = e_adr + 16'd1;
  endtask

  task automatic grant_idle();
    #1 chk("gnt_idle", ps2fc_gnt_o, 1);
    step();
    fc2ps_req_i = 1'b0;
  endtask

  task automatic addr_phase(input int nst);
    for (int i = 0; i <= nst; i++) begin
      pbus_stall_i = (i < nst);
      chk("addr_cyc", pbus_cyc_o, 1);
      chk("addr_stb", pbus_stb_o, 1);
      chk("addr_adr", pbus_adr_o, e_adr);
      chk("addr_we", pbus_we_o, e_typ == TYP_WR);
      chk("addr_dat", pbus_dat_o, e_wd);
      chk("addr_tga_cof", pbus_tga_cof_o, e_typ == TYP_COF);
      chk("addr_tga_dat", pbus_tga_dat_o, e_typ == TYP_RD || e_typ == TYP_WR);
      chk("addr_pc", ps_pc_o, m_pc);
      step();
    end
    pbus_stall_i = 1'b0;
  endtask

  // term: 0 ack, 1 err, 2 ack+err
  task automatic data_begin(input int term, input logic [15:0] bd);
    chk("data_cyc", pbus_cyc_o, 1);
    chk("data_stb", pbus_stb_o, 0);
    d_typ = e_typ; d_term = term; d_bd = bd;
    pbus_ack_i = (term != 1);
    pbus_err_i = (term != 0);
    pbus_dat_i = bd;
  endtask

  task automatic data_end(input bit chain);
    #1 chk("gnt_term", ps2fc_gnt_o, chain);
    step();
    pbus_ack_i = 1'b0; pbus_err_i = 1'b0;
    if (chain) fc2ps_req_i = 1'b0;
    if (d_term == 0 && (d_typ == TYP_SEQ || d_typ == TYP_COF)) m_opc = d_bd;
    if (d_term == 0 && d_typ == TYP_RD) m_rdat = d_bd;
    chk("err_pulse", ps2fc_err_o, d_term != 0);
    chk("opc_vld", ps2ir_opc_vld_o, d_term == 0 && (d_typ == TYP_SEQ || d_typ == TYP_COF));
    chk("rdat_vld", ps2dat_rdat_vld_o, d_term == 0 && d_typ == TYP_RD);
    chk("opc", ps2ir_opc_o, m_opc);
    chk("rdat", ps2dat_rdat_o, m_rdat);
    chk("pc", ps_pc_o, m_pc);
    chk("cyc_after", pbus_cyc_o, chain);
  endtask

  task automatic idle_stray(input logic err);
    pbus_ack_i = 1'b1; pbus_err_i = err; pbus_dat_i = 16'hDEAD;
    step();
    pbus_ack_i = 1'b0; pbus_err_i = 1'b0;
    chk("stray_vld", {ps2fc_err_o, ps2ir_opc_vld_o, ps2dat_rdat_vld_o}, 0);
    chk("stray_cyc", pbus_cyc_o, 0);
    chk("stray_pc", ps_pc_o, m_pc);
    chk("stray_opc", ps2ir_opc_o, m_opc);
  endtask

  task automatic rand_present();
    logic [1:0] t;
    t = 2'($urandom_range(0, 3));
    present(t, 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    bit pend, chain;
    async_rst_n_i = 1'b0; fc2ps_req_i = 1'b0; fc2ps_typ_i = TYP_SEQ; fc2ps_wdat_i = 16'h0;
    pagu2ps_adr_sel_i = 1'b0; pagu2ps_aadr_i = 16'h0; pagu2ps_radr_i = 16'h0;
    pbus_ack_i = 1'b0; pbus_err_i = 1'b0; pbus_stall_i = 1'b0; pbus_dat_i = 16'h0;
    m_pc = 16'h0000; m_opc = 16'h0000; m_rdat = 16'h0000;
    #12;
    chk("rst_cyc", {pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_tga_cof_o, pbus_tga_dat_o}, 0);
    chk("rst_pulses", {ps2fc_gnt_o, ps2fc_err_o, ps2ir_opc_vld_o, ps2dat_rdat_vld_o}, 0);
    chk("rst_pc", ps_pc_o, 16'h0000);
    chk("rst_adr", pbus_adr_o, 16'h0000);
    chk("rst_opc", ps2ir_opc_o, 16'h0000);
    step();
    async_rst_n_i = 1'b1;

    // Sequential fetch straight out of reset
    present(TYP_SEQ, 16'h0, 1'b0, 16'h0, 16'h0);
    grant_idle(); addr_phase(0); data_begin(0, 16'hA5A5); data_end(0);

    // Absolute COF with 3 stall cycles
    present(TYP_COF, 16'h0, 1'b1, 16'h1234, 16'h5555);
    grant_idle(); addr_phase(3); data_begin(0, 16'h0F0F); data_end(0);
    chk("cof_pc", ps_pc_o, 16'h1235);

    // Relative COF to FFFE, then SEQ wrap
    present(TYP_COF, 16'h0, 1'b0, 16'h7777, 16'hFFFE);
    grant_idle(); addr_phase(0); data_begin(0, 16'h1111); data_end(0);
    present(TYP_SEQ, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("wrap_adr_pre_pc", ps_pc_o, 16'hFFFF);
    grant_idle(); addr_phase(1); data_begin(0, 16'h2222); data_end(0);
    chk("wrap_pc", ps_pc_o, 16'h0000);

    // Write, back-to-back read granted in the ack cycle
    present(TYP_WR, 16'hBEEF, 1'b0, 16'h0040, 16'h0);
    grant_idle(); addr_phase(0); data_begin(0, 16'h3333);
    present(TYP_RD, 16'h0, 1'b0, 16'h0080, 16'h0);
    data_end(1);
    addr_phase(0); data_begin(0, 16'hC0DE); data_end(0);
    chk("wr_rd_pc", ps_pc_o, 16'h0000);

    // err together with ack
    present(TYP_RD, 16'h0, 1'b0, 16'h0100, 16'h0);
    grant_idle(); addr_phase(0); data_begin(2, 16'h4444); data_end(0);
    idle_stray(1'b0);

    // Reset while in DATA; late ack ignored
    present(TYP_SEQ, 16'h0, 1'b0, 16'h0, 16'h0);
    grant_idle(); addr_phase(0);
    async_rst_n_i = 1'b0;
    #1;
    m_pc = 16'h0000; m_opc = 16'h0000; m_rdat = 16'h0000;
    chk("mid_rst_cyc", {pbus_cyc_o, pbus_stb_o}, 0);
    chk("mid_rst_pc", ps_pc_o, 16'h0000);
    chk("mid_rst_adr", pbus_adr_o, 16'h0000);
    chk("mid_rst_opc", ps2ir_opc_o, 16'h0000);
    pbus_ack_i = 1'b1; pbus_dat_i = 16'h9999;
    step();
    async_rst_n_i = 1'b1;
    idle_stray(1'b0);

    // Randomized traffic
    pend = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (!pend) begin
        rand_present();
        grant_idle();
      end
      addr_phase($urandom_range(0, 3));
      data_begin(($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0, 16'($urandom));
      chain = 1'($urandom);
      if (chain) rand_present();
      data_end(chain);
      pend = chain;
      if (!pend && $urandom_range(0, 3) == 0) idle_stray(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
